fsm_mult_ctrl_param: RTL and testbench
======================================

Name: fsm_mult_ctrl_param

Overview:
- Parametrised control FSM for the floating-point multiplier datapath: operand load, exponent add and bias subtract, significand normalisation, rounding, final load, ready/ack handshake.
- Next generation of the fixed single/double multiplier controller:
  - configurable significand-multiplier latency (wait counter);
  - optional auto-acknowledge;
  - busy status;
  - compile-time exponent-exception early exit.
- Sits beside the multiplier datapath; drives all its register loads and mux selects.

Parameters:
- MULT_LATENCY, 1, cycles waited after operand load before exponent/zero evaluation (0..15; 0 skips the wait state).
- AUTO_ACK, 0, 1 = READY lasts one cycle and returns to IDLE without ack_fsm_i.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- beg_fsm_i  in  1  start request, sampled in IDLE only.
- ack_fsm_i  in  1  result acknowledge, sampled in READY only.
- zero_flag_i  in  1  an operand is zero.
- mult_shift_i  in  1  significand product overflow (needs right shift).
- round_flag_i  in  1  rounding increment required.
- add_overflow_i  in  1  round adder carry-out.
- exp_overflow_i  in  1  biased exponent overflow (used only with the macro).
- exp_underflow_i  in  1  biased exponent underflow (used only with the macro).
- load_o  out  7  register loads [0]=operands, [1]=zero/sign/sgf1, [2]=exp result, [3]=exp ovf/sgf2, [4]=round adder, [5]=final, [6]=shifter.
- ctrl_select_a_o  out  1  mux A select.
- ctrl_select_b_o  out  1  mux B enable.
- selector_b_o  out  2  mux B operand: 01 = bias/one, 10 = normalisation increment.
- ctrl_select_c_o  out  1  round adder input select.
- exp_op_o  out  1  exponent unit: 0 = add, 1 = subtract.
- shift_value_o  out  1  barrel shifter: 1 = shift right by one.
- exc_sel_o  out  2  final-result override: 00 = none, 01 = overflow/inf, 10 = underflow/zero.
- rst_int_o  out  1  internal datapath reset.
- ready_o  out  1  result valid.
- busy_o  out  1  high in every state except IDLE.

Behaviour:
- State register: async reset to IDLE. Counter: async reset to 0.
- All outputs are combinational from the state and inputs. Any output not listed for a state is 0.
- After reset, outputs are: rst_int_o=1, all others 0.
- State sequence and outputs:
  - IDLE: rst_int_o=1. If beg_fsm_i, go to LOAD.
  - LOAD: load_o[0]=1. Clear the counter. Go to WAIT if MULT_LATENCY>0, else ADD_EXP.
  - WAIT: increment the counter. When the counter equals MULT_LATENCY-1, go to ADD_EXP. WAIT lasts exactly MULT_LATENCY cycles.
  - ADD_EXP: load_o[1]=1, load_o[2]=1, ctrl_select_a_o=1, ctrl_select_b_o=1, selector_b_o=01. Go to SUBT_BIAS.
  - SUBT_BIAS: load_o[2]=1, load_o[3]=1, exp_op_o=1.
    - zero_flag_i: go to READY (highest priority).
    - Else, exception (macro only): go to EXC_LOAD.
    - Else: go to MULT_OVF.
  - MULT_OVF:
    - If mult_shift_i: ctrl_select_b_o=1, selector_b_o=10, go to MULT_NORM.
    - Else: go to MULT_NONORM.
  - MULT_NORM: shift_value_o=1, load_o[6]=1, load_o[2]=1, load_o[3]=1. Go to ROUND_CASE.
  - MULT_NONORM: load_o[6]=1. Go to ROUND_CASE.
  - ROUND_CASE:
    - If round_flag_i: ctrl_select_c_o=1, go to ADDER_ROUND.
    - Else: go to FINAL_LOAD.
  - ADDER_ROUND: load_o[4]=1, ctrl_select_b_o=1, selector_b_o=01. Go to ROUND_NORM.
  - ROUND_NORM: load_o[6]=1. If add_overflow_i, also shift_value_o=1, load_o[2]=1, load_o[3]=1. Go to FINAL_LOAD.
  - FINAL_LOAD: load_o[5]=1. Go to READY.
  - READY: ready_o=1.
    - AUTO_ACK=0: hold until ack_fsm_i, then go to IDLE.
    - AUTO_ACK=1: go to IDLE unconditionally.
- Zero path skips FINAL_LOAD. The datapath zero-forces the result; no load_o[5].
- Latency, beg_fsm_i high to ready_o high, with MULT_LATENCY=1:
  - zero: 5 cycles;
  - no-round: 9 cycles;
  - round: 11 cycles.
- Each increment of MULT_LATENCY adds 1 cycle.
- Boundary cases:
  - beg_fsm_i outside IDLE: ignored.
  - ack_fsm_i outside READY: ignored.
  - ack_fsm_i and beg_fsm_i both high in READY: go to IDLE. The new operation starts only from IDLE on the next beg_fsm_i.
  - rst mid-operation: return to IDLE immediately; any pending load pulses are dropped.
  - Unused state encodings: go to IDLE with all outputs 0 except rst_int_o=0.
- Encoding: 4-bit state register. Counter width 4 bits.

Optional Feature:
- Macro: FSM_MULT_EXC_EN.
- Defined:
  - In SUBT_BIAS with zero_flag_i=0, if exp_overflow_i or exp_underflow_i, go to EXC_LOAD. Overflow has priority when both are set.
  - EXC_LOAD: load_o[5]=1; exc_sel_o=01 for overflow, 10 for underflow (choice registered on SUBT_BIAS exit). Go to READY.
  - exc_sel_o holds its value through READY; cleared in IDLE.
- Undefined: the exception inputs are ignored, EXC_LOAD does not exist, and exc_sel_o is tied to 00.

Test Plan:
- Reset, then hold beg_fsm_i=0 for 5 cycles -> rst_int_o=1, busy_o=0, load_o=0000000 throughout.
- MULT_LATENCY=3, beg_fsm_i pulse, all flags 0, ack_fsm_i=1 in READY:
  - load_o[0] at cycle 1, ADD_EXP at cycle 5, load_o[5] at cycle 10, ready_o at cycle 11;
  - IDLE one cycle after ack.
- mult_shift_i=1, round_flag_i=1, add_overflow_i=1:
  - selector_b_o=10 in MULT_OVF; shift_value_o=1 in both MULT_NORM and ROUND_NORM;
  - load_o[4] pulsed once; ready_o 11 cycles after beg.
- zero_flag_i=1 at SUBT_BIAS -> ready_o next cycle, load_o[5] never asserted.
- AUTO_ACK=1 -> ready_o high exactly 1 cycle, then IDLE. AUTO_ACK=0 with ack delayed 4 cycles -> ready_o high 5 cycles.
- Assert rst during WAIT -> IDLE at once, counter 0. With FSM_MULT_EXC_EN and exp_overflow_i=exp_underflow_i=1 -> exc_sel_o=01, load_o[5]=1, then READY.

Source files
------------

// File: rtl/fsm_mult_ctrl_param.sv
// rtl/fsm_mult_ctrl_param.sv - control FSM for the floating-point multiplier datapath
// Optional exponent-exception early exit enabled by defining FSM_MULT_EXC_EN.
module fsm_mult_ctrl_param #(
  parameter int MULT_LATENCY = 1,
  parameter bit AUTO_ACK     = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       beg_fsm_i,
  input  logic       ack_fsm_i,
  input  logic       zero_flag_i,
  input  logic       mult_shift_i,
  input  logic       round_flag_i,
  input  logic       add_overflow_i,
  input  logic       exp_overflow_i,
  input  logic       exp_underflow_i,
  output logic [6:0] load_o,
  output logic       ctrl_select_a_o,
  output logic       ctrl_select_b_o,
  output logic [1:0] selector_b_o,
  output logic       ctrl_select_c_o,
  output logic       exp_op_o,
  output logic       shift_value_o,
  output logic [1:0] exc_sel_o,
  output logic       rst_int_o,
  output logic       ready_o,
  output logic       busy_o
);

  typedef enum logic [3:0] {
    IDLE        = 4'd0,
    LOAD        = 4'd1,
    WAIT        = 4'd2,
    ADD_EXP     = 4'd3,
    SUBT_BIAS   = 4'd4,
    MULT_OVF    = 4'd5,
    MULT_NORM   = 4'd6,
    MULT_NONORM = 4'd7,
    ROUND_CASE  = 4'd8,
    ADDER_ROUND = 4'd9,
    ROUND_NORM  = 4'd10,
    FINAL_LOAD  = 4'd11,
    READY       = 4'd12,
    EXC_LOAD    = 4'd13
  } state_t;

  localparam logic [3:0] LAT_LAST = (MULT_LATENCY > 0) ? 4'(MULT_LATENCY - 1) : 4'd0;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

`ifdef FSM_MULT_EXC_EN
  logic [1:0] exc_q, exc_d;
`else
  logic unused_exc;
  assign unused_exc = exp_overflow_i | exp_underflow_i;
`endif

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
`ifdef FSM_MULT_EXC_EN
    exc_d           = exc_q;
`endif
    load_o          = 7'b0;
    ctrl_select_a_o = 1'b0;
    ctrl_select_b_o = 1'b0;
    selector_b_o    = 2'b00;
    ctrl_select_c_o = 1'b0;
    exp_op_o        = 1'b0;
    shift_value_o   = 1'b0;
    exc_sel_o       = 2'b00;
    rst_int_o       = 1'b0;
    ready_o         = 1'b0;
    busy_o          = 1'b1;
    unique case (state_q)
      IDLE: begin
        busy_o    = 1'b0;
        rst_int_o = 1'b1;
`ifdef FSM_MULT_EXC_EN
        exc_d     = 2'b00;
`endif
        if (beg_fsm_i) state_d = LOAD;
      end
      LOAD: begin
        load_o[0] = 1'b1;
        cnt_d     = 4'd0;
        state_d   = (MULT_LATENCY > 0) ? WAIT : ADD_EXP;
      end
      WAIT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAT_LAST) state_d = ADD_EXP;
      end
      ADD_EXP: begin
        load_o[1]       = 1'b1;
        load_o[2]       = 1'b1;
        ctrl_select_a_o = 1'b1;
        ctrl_select_b_o = 1'b1;
        selector_b_o    = 2'b01;
        state_d         = SUBT_BIAS;
      end
      SUBT_BIAS: begin
        load_o[2] = 1'b1;
        load_o[3] = 1'b1;
        exp_op_o  = 1'b1;
        if (zero_flag_i) begin
          state_d = READY;
`ifdef FSM_MULT_EXC_EN
        end else if (exp_overflow_i || exp_underflow_i) begin
          exc_d   = exp_overflow_i ? 2'b01 : 2'b10;
          state_d = EXC_LOAD;
`endif
        end else begin
          state_d = MULT_OVF;
        end
      end
      MULT_OVF: begin
        if (mult_shift_i) begin
          ctrl_select_b_o = 1'b1;
          selector_b_o    = 2'b10;
          state_d         = MULT_NORM;
        end else begin
          state_d = MULT_NONORM;
        end
      end
      MULT_NORM: begin
        shift_value_o = 1'b1;
        load_o[6]     = 1'b1;
        load_o[2]     = 1'b1;
        load_o[3]     = 1'b1;
        state_d       = ROUND_CASE;
      end
      MULT_NONORM: begin
        load_o[6] = 1'b1;
        state_d   = ROUND_CASE;
      end
      ROUND_CASE: begin
        if (round_flag_i) begin
          ctrl_select_c_o = 1'b1;
          state_d         = ADDER_ROUND;
        end else begin
          state_d = FINAL_LOAD;
        end
      end
      ADDER_ROUND: begin
        load_o[4]       = 1'b1;
        ctrl_select_b_o = 1'b1;
        selector_b_o    = 2'b01;
        state_d         = ROUND_NORM;
      end
      ROUND_NORM: begin
        load_o[6] = 1'b1;
        if (add_overflow_i) begin
          shift_value_o = 1'b1;
          load_o[2]     = 1'b1;
          load_o[3]     = 1'b1;
        end
        state_d = FINAL_LOAD;
      end
      FINAL_LOAD: begin
        load_o[5] = 1'b1;
        state_d   = READY;
      end
`ifdef FSM_MULT_EXC_EN
      EXC_LOAD: begin
        load_o[5] = 1'b1;
        exc_sel_o = exc_q;
        state_d   = READY;
      end
`endif
      READY: begin
        ready_o = 1'b1;
`ifdef FSM_MULT_EXC_EN
        exc_sel_o = exc_q;
`endif
        if (AUTO_ACK || ack_fsm_i) state_d = IDLE;
      end
      default: begin
        // Corrupted encoding: recover to IDLE with every output, rst_int_o included, low.
        busy_o  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
`ifdef FSM_MULT_EXC_EN
      exc_q   <= 2'b00;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef FSM_MULT_EXC_EN
      exc_q   <= exc_d;
`endif
    end
  end

endmodule

// File: tb/tb_fsm_mult_ctrl_param.sv
// tb/tb_fsm_mult_ctrl_param.sv - randomized trace-model bench for fsm_mult_ctrl_param
// Three instances (latency 3/1/0, auto-ack on instance 1); honours FSM_MULT_EXC_EN.
module tb_fsm_mult_ctrl_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic beg [3];
  logic ack [3];
  logic zero_f, shift_f, round_f, addovf_f, expovf_f, expunf_f;
  logic [18:0] obs [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int ML = (g == 0) ? 3 : ((g == 1) ? 1 : 0);
    logic [6:0] load;
    logic sa, sb, sc, eop, sv, ri, rdy, bsy;
    logic [1:0] sbv, ex;
    fsm_mult_ctrl_param #(.MULT_LATENCY(ML), .AUTO_ACK(g == 1)) u_dut (
      .clk(clk), .rst(rst), .beg_fsm_i(beg[g]), .ack_fsm_i(ack[g]),
      .zero_flag_i(zero_f), .mult_shift_i(shift_f), .round_flag_i(round_f),
      .add_overflow_i(addovf_f), .exp_overflow_i(expovf_f), .exp_underflow_i(expunf_f),
      .load_o(load), .ctrl_select_a_o(sa), .ctrl_select_b_o(sb), .selector_b_o(sbv),
      .ctrl_select_c_o(sc), .exp_op_o(eop), .shift_value_o(sv), .exc_sel_o(ex),
      .rst_int_o(ri), .ready_o(rdy), .busy_o(bsy)
    );
    assign obs[g] = {load, sa, sb, sbv, sc, eop, sv, ex, ri, rdy, bsy};
  end

  function automatic logic [18:0] mk(input logic [6:0] ld, input logic sa, input logic sb,
                                     input logic [1:0] sbv, input logic sc, input logic eop,
                                     input logic sv, input logic [1:0] ex, input logic ri,
                                     input logic rdy, input logic bsy);
    return {ld, sa, sb, sbv, sc, eop, sv, ex, ri, rdy, bsy};
  endfunction

  function automatic int ml_of(input int g);
    return (g == 0) ? 3 : ((g == 1) ? 1 : 0);
  endfunction

  logic [18:0] idle_w;
  assign idle_w = mk(7'h00, 0, 0, 2'b00, 0, 0, 0, 2'b00, 1, 0, 0);

  // Expected per-cycle output words, bit 19 marks the cycle beg_fsm_i is raised.
  logic [19:0] q0[$], q1[$], q2[$];
  logic [18:0] tr[$];

  task automatic push(input int g, input logic [19:0] v);
    case (g)
      0: q0.push_back(v);
      1: q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  int cyc [3], lat [3], f5 [3], l5 [3], l4 [3], shc [3], rl [3];
  logic [1:0] exo [3];

  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      logic [19:0] e;
      e = {1'b0, idle_w};
      case (g)
        0: if (q0.size() > 0) e = q0.pop_front();
        1: if (q1.size() > 0) e = q1.pop_front();
        default: if (q2.size() > 0) e = q2.pop_front();
      endcase
      if (e[19]) begin
        cyc[g] = 0; lat[g] = -1; f5[g] = -1; l5[g] = 0; l4[g] = 0; shc[g] = 0; rl[g] = 0;
        exo[g] = 2'b00;
      end
      n_tests++;
      if (obs[g] !== e[18:0]) begin
        n_fail++;
        $display("FAIL outputs dut%0d t=%0t got %b want %b", g, $time, obs[g], e[18:0]);
      end
      if (obs[g][1] && lat[g] < 0) lat[g] = cyc[g];
      if (obs[g][17] && f5[g] < 0) f5[g] = cyc[g];
      if (obs[g][1]) rl[g]++;
      if (obs[g][17]) l5[g]++;
      if (obs[g][16]) l4[g]++;
      if (obs[g][5]) shc[g]++;
      if (obs[g][4:3] != 2'b00) exo[g] = obs[g][4:3];
      cyc[g]++;
    end
  end

  // Builds the cycle-by-cycle output sequence of one operation from the phase list.
  task automatic build(input int g, input logic z, input logic sh, input logic rd,
                       input logic ao, input logic eo, input logic eu, input int d);
    logic [1:0] ex;
    logic exc_path;
    ex = 2'b00;
    exc_path = 1'b0;
`ifdef FSM_MULT_EXC_EN
    if (!z && (eo || eu)) begin
      ex = eo ? 2'b01 : 2'b10;
      exc_path = 1'b1;
    end
`endif
    tr.delete();
    tr.push_back(idle_w);
    tr.push_back(mk(7'h01, 0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 1));
    for (int i = 0; i < ml_of(g); i++) tr.push_back(mk(7'h00, 0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 1));
    tr.push_back(mk(7'b0000110, 1, 1, 2'b01, 0, 0, 0, 2'b00, 0, 0, 1));
    tr.push_back(mk(7'b0001100, 0, 0, 2'b00, 0, 1, 0, 2'b00, 0, 0, 1));
    if (!z && exc_path) begin
      tr.push_back(mk(7'b0100000, 0, 0, 2'b00, 0, 0, 0, ex, 0, 0, 1));
    end else if (!z) begin
      tr.push_back(mk(7'h00, 0, sh, sh ? 2'b10 : 2'b00, 0, 0, 0, 2'b00, 0, 0, 1));
      tr.push_back(mk(sh ? 7'b1001100 : 7'b1000000, 0, 0, 2'b00, 0, 0, sh, 2'b00, 0, 0, 1));
      tr.push_back(mk(7'h00, 0, 0, 2'b00, rd, 0, 0, 2'b00, 0, 0, 1));
      if (rd) begin
        tr.push_back(mk(7'b0010000, 0, 1, 2'b01, 0, 0, 0, 2'b00, 0, 0, 1));
        tr.push_back(mk(ao ? 7'b1001100 : 7'b1000000, 0, 0, 2'b00, 0, 0, ao, 2'b00, 0, 0, 1));
      end
      tr.push_back(mk(7'b0100000, 0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 1));
    end
    for (int i = 0; i < ((g == 1) ? 1 : d + 1); i++)
      tr.push_back(mk(7'h00, 0, 0, 2'b00, 0, 0, 0, ex, 0, 1, 1));
  endtask

  task automatic run_op(input int g, input logic z, input logic sh, input logic rd,
                        input logic ao, input logic eo, input logic eu, input int d);
    int rdyi;
    build(g, z, sh, rd, ao, eo, eu, d);
    rdyi = 0;
    for (int i = 0; i < tr.size(); i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        zero_f = z; shift_f = sh; round_f = rd; addovf_f = ao; expovf_f = eo; expunf_f = eu;
      end
      beg[g] = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (tr[i][1] && g != 1) begin
        ack[g] = (rdyi == d);
        rdyi++;
      end else begin
        ack[g] = 1'($urandom_range(0, 1));
      end
      push(g, {(i == 0), tr[i]});
    end
    @(posedge clk); #1;
    beg[g] = 1'b0;
    ack[g] = 1'b0;
  endtask

  task automatic chk(input string nm, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask

  initial begin
    for (int g = 0; g < 3; g++) begin beg[g] = 1'b0; ack[g] = 1'b0; end
    zero_f = 0; shift_f = 0; round_f = 0; addovf_f = 0; expovf_f = 0; expunf_f = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("reset_idle_word", int'(obs[0]), int'(mk(7'h00, 0, 0, 2'b00, 0, 0, 0, 2'b00, 1, 0, 0)));

    run_op(1, 1, 0, 0, 0, 0, 0, 0);
    chk("ml1_zero_latency", lat[1], 5);
    chk("ml1_zero_no_final_load", l5[1], 0);
    chk("ml1_zero_autoack_ready_len", rl[1], 1);
    run_op(1, 0, 0, 0, 0, 0, 0, 0);
    chk("ml1_noround_latency", lat[1], 9);
    run_op(1, 0, 1, 1, 1, 0, 0, 0);
    chk("ml1_round_latency", lat[1], 11);
    chk("ml1_round_adder_pulses", l4[1], 1);
    chk("ml1_round_shift_cycles", shc[1], 2);
    run_op(0, 0, 0, 0, 0, 0, 0, 4);
    chk("ml3_final_load_cycle", f5[0], 10);
    chk("ml3_ready_cycle", lat[0], 11);
    chk("ml3_ready_len_ack_delay4", rl[0], 5);
    run_op(0, 1, 0, 0, 0, 0, 0, 0);
    chk("ml3_zero_latency", lat[0], 7);
    chk("ml3_zero_no_final_load", l5[0], 0);
    run_op(2, 0, 0, 0, 0, 0, 0, 1);
    chk("ml0_noround_latency", lat[2], 8);
    run_op(0, 0, 0, 0, 0, 1, 1, 0);
`ifdef FSM_MULT_EXC_EN
    chk("exc_both_sel", int'(exo[0]), 1);
    chk("exc_both_latency", lat[0], 8);
    chk("exc_both_final_load", l5[0], 1);
    run_op(0, 0, 0, 0, 0, 0, 1, 0);
    chk("exc_unf_sel", int'(exo[0]), 2);
`else
    chk("exc_ignored_latency", lat[0], 11);
    chk("exc_ignored_sel", int'(exo[0]), 0);
`endif

    // Reset in the first WAIT cycle of instance 0.
    @(posedge clk); #1;
    beg[0] = 1'b1;
    push(0, {1'b1, idle_w});
    @(posedge clk); #1;
    beg[0] = 1'b0;
    push(0, {1'b0, mk(7'h01, 0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 1)});
    @(posedge clk); #1;
    push(0, {1'b0, mk(7'h00, 0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 1)});
    #6 rst = 1'b1;
    #1 chk("rst_mid_wait_idle", int'(obs[0]), int'(idle_w));
    @(posedge clk); #1;
    rst = 1'b0;
    run_op(0, 0, 0, 0, 0, 0, 0, 0);
    chk("post_rst_wait_restart", lat[0], 11);

    for (int n = 0; n < 300; n++) begin
      run_op(int'($urandom_range(0, 2)), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 3) == 0), int'($urandom_range(0, 5)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
